// File: rtl/native_bus_dma.sv
// ---------------------------------------------------------------------------
// native_bus_dma
//   Single-channel word-copy DMA. It is programmed through a native-bus
//   register responder. It then copies LEN 32-bit words from SRC to DST over
//   a native-bus initiator port. Each word is one read followed by one write,
//   with a single m_valid-low cycle after every handshake.
//
// Ports
//   clk, rst        : clock; asynchronous active-high reset
//   cfg_valid       : register access request (cfg_wstrb == 0 means read)
//   cfg_ready       : one-cycle acknowledge, raised the cycle after acceptance
//   cfg_addr[3:2]   : 0 SRC, 1 DST, 2 LEN, 3 CTRL(write) / STATUS(read)
//   cfg_wdata/wstrb : write data and byte enables
//   cfg_rdata       : registered read data, valid while cfg_ready is high
//   m_valid/m_ready : initiator handshake
//   m_addr/m_wdata  : initiator address / write data (stable while m_valid)
//   m_wstrb         : 4'b0000 for reads, 4'b1111 for writes
//   m_rdata         : read data, captured on the read handshake
//   done_o          : sticky DONE flag
// ---------------------------------------------------------------------------
module native_bus_dma #(
    parameter int LEN_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [3:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    input  logic [3:0]  cfg_wstrb,
    output logic [31:0] cfg_rdata,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic [31:0] m_rdata,
    output logic        done_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD_REQ = 3'd1;
    localparam logic [2:0] S_RD_GAP = 3'd2;
    localparam logic [2:0] S_WR_REQ = 3'd3;
    localparam logic [2:0] S_WR_GAP = 3'd4;

    logic [2:0]       state;
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [31:0]      data_q;
    logic [LEN_W-1:0] len;
    logic             done_q;
    logic             aborted_q;
    logic             abort_pend;
    logic             zero_start_pend;

    logic             cfg_acc;
    logic             cfg_wr;
    logic [1:0]       reg_sel;
    logic             ctrl_wr;
    logic             start_cmd;
    logic             clr_cmd;
    logic             abort_cmd;
    logic             busy;
    logic             abort_eff;
    logic [31:0]      rd_mux;
    logic             unused_addr_bits;

    // Byte-lane merge of a register write.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [LEN_W-1:0] merge_len(input logic [LEN_W-1:0] old_v,
                                                   input logic [31:0]      new_v,
                                                   input logic [3:0]       strb);
        logic [31:0] r;
        r = merge_bytes(32'(old_v), new_v, strb);
        return r[LEN_W-1:0];
    endfunction

    // Word-aligned registers never hold address bits [1:0].
    function automatic logic [31:0] word_align(input logic [31:0] v);
        return v & ~32'h3;
    endfunction

    assign unused_addr_bits = ^cfg_addr[1:0];

    // An access is accepted when seen with cfg_ready low; cfg_ready then
    // pulses for exactly one cycle, so back-to-back requests alternate.
    assign cfg_acc   = cfg_valid & ~cfg_ready;
    assign cfg_wr    = cfg_acc & (|cfg_wstrb);
    assign reg_sel   = cfg_addr[3:2];
    assign ctrl_wr   = cfg_wr & (reg_sel == 2'd3) & cfg_wstrb[0];
    assign start_cmd = ctrl_wr & cfg_wdata[0];
    assign clr_cmd   = ctrl_wr & cfg_wdata[1];
    assign abort_cmd = ctrl_wr & cfg_wdata[2];
    assign busy      = (state != S_IDLE);
    // An abort takes effect on the same edge it is written as well as later.
    assign abort_eff = busy & (abort_pend | abort_cmd);
    assign done_o    = done_q;

    always_comb begin
        rd_mux = 32'h0;
        case (reg_sel)
            2'd0:    rd_mux = src;
            2'd1:    rd_mux = dst;
            2'd2:    rd_mux = 32'(len);
            default: rd_mux = {29'h0, aborted_q, done_q, busy};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            src             <= 32'h0;
            dst             <= 32'h0;
            len             <= '0;
            data_q          <= 32'h0;
            done_q          <= 1'b0;
            aborted_q       <= 1'b0;
            abort_pend      <= 1'b0;
            zero_start_pend <= 1'b0;
            cfg_ready       <= 1'b0;
            cfg_rdata       <= 32'h0;
            m_valid         <= 1'b0;
            m_addr          <= 32'h0;
            m_wdata         <= 32'h0;
            m_wstrb         <= 4'h0;
        end else begin
            cfg_ready       <= cfg_acc;
            zero_start_pend <= 1'b0;
            if (cfg_acc) begin
                cfg_rdata <= rd_mux;
            end

            // Programming registers are frozen while a transfer runs.
            if (cfg_wr && !busy) begin
                case (reg_sel)
                    2'd0:    src <= word_align(merge_bytes(src, cfg_wdata, cfg_wstrb));
                    2'd1:    dst <= word_align(merge_bytes(dst, cfg_wdata, cfg_wstrb));
                    2'd2:    len <= merge_len(len, cfg_wdata, cfg_wstrb);
                    default: ;
                endcase
            end

            // CLRDONE first so that any completion below on the same edge wins.
            if (clr_cmd) begin
                done_q <= 1'b0;
            end
            if (zero_start_pend) begin
                done_q <= 1'b1;
            end
            if (abort_cmd && busy) begin
                abort_pend <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start_cmd) begin
                        if (len != '0) begin
                            done_q    <= 1'b0;
                            aborted_q <= 1'b0;
                            state     <= S_RD_REQ;
                        end else begin
                            // DONE appears one cycle later, after the ack pulse.
                            zero_start_pend <= 1'b1;
                        end
                    end
                end

                S_RD_REQ: begin
                    // m_valid is still low only in the first cycle after START.
                    if (!m_valid) begin
                        if (abort_eff) begin
                            state      <= S_IDLE;
                            aborted_q  <= 1'b1;
                            abort_pend <= 1'b0;
                        end else begin
                            m_valid <= 1'b1;
                            m_addr  <= src;
                            m_wstrb <= 4'h0;
                        end
                    end else if (m_ready) begin
                        data_q  <= m_rdata;
                        m_valid <= 1'b0;
                        if (abort_eff) begin
                            state      <= S_IDLE;
                            aborted_q  <= 1'b1;
                            abort_pend <= 1'b0;
                        end else begin
                            state <= S_RD_GAP;
                        end
                    end
                end

                S_RD_GAP: begin
                    if (abort_eff) begin
                        state      <= S_IDLE;
                        aborted_q  <= 1'b1;
                        abort_pend <= 1'b0;
                    end else begin
                        state   <= S_WR_REQ;
                        m_valid <= 1'b1;
                        m_addr  <= dst;
                        m_wdata <= data_q;
                        m_wstrb <= 4'hF;
                    end
                end

                S_WR_REQ: begin
                    if (m_valid && m_ready) begin
                        src     <= src + 32'd4;
                        dst     <= dst + 32'd4;
                        len     <= len - LEN_W'(1);
                        m_valid <= 1'b0;
                        m_wstrb <= 4'h0;
                        if (abort_eff) begin
                            state      <= S_IDLE;
                            aborted_q  <= 1'b1;
                            abort_pend <= 1'b0;
                        end else begin
                            state <= S_WR_GAP;
                        end
                    end
                end

                S_WR_GAP: begin
                    if (abort_eff) begin
                        state      <= S_IDLE;
                        aborted_q  <= 1'b1;
                        abort_pend <= 1'b0;
                    end else if (len != '0) begin
                        state   <= S_RD_REQ;
                        m_valid <= 1'b1;
                        m_addr  <= src;
                        m_wstrb <= 4'h0;
                    end else begin
                        state  <= S_IDLE;
                        done_q <= 1'b1;
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_native_bus_dma.sv
`timescale 1ns/1ps
module tb_native_bus_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [3:0]  cfg_addr = 4'h0;
    logic [31:0] cfg_wdata = 32'h0;
    logic [3:0]  cfg_wstrb = 4'h0;
    logic [31:0] cfg_rdata;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [31:0] m_rdata = 32'h0;
    logic        done_o;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [3:0] A_SRC  = 4'h0;
    localparam logic [3:0] A_DST  = 4'h4;
    localparam logic [3:0] A_LEN  = 4'h8;
    localparam logic [3:0] A_CTRL = 4'hC;

    always #5 clk = ~clk;

    native_bus_dma #(.LEN_W(16)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_wstrb(cfg_wstrb), .cfg_rdata(cfg_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata),
        .done_o(done_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    txn_t txq[$];
    int   gap_q[$];
    int   lat = 1;
    int   hold_cnt = 0;
    int   low_cnt = 0;
    bit   prev_valid = 1'b0;
    bit   after_hs = 1'b0;
    int   stab_err = 0;
    int   drop_err = 0;
    logic [31:0] p_addr = 32'h0;
    logic [31:0] p_wdata = 32'h0;
    logic [3:0]  p_wstrb = 4'h0;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory responder with programmable latency, transaction log and
    // protocol watch (stability while valid, no drop before ready, gaps).
    always @(negedge clk) begin
        txn_t t;
        if (rst) begin
            m_ready    = 1'b0;
            hold_cnt   = 0;
            prev_valid = 1'b0;
            after_hs   = 1'b0;
            low_cnt    = 0;
        end else begin
            if (m_ready) begin
                m_ready    = 1'b0;
                hold_cnt   = 0;
                prev_valid = 1'b0;
                after_hs   = 1'b1;
                low_cnt    = 0;
            end
            if (m_valid) begin
                if (prev_valid && (m_addr !== p_addr || m_wdata !== p_wdata || m_wstrb !== p_wstrb))
                    stab_err++;
                if (after_hs) begin
                    gap_q.push_back(low_cnt);
                    after_hs = 1'b0;
                end
                prev_valid = 1'b1;
                p_addr  = m_addr;
                p_wdata = m_wdata;
                p_wstrb = m_wstrb;
                hold_cnt++;
                if (hold_cnt >= lat) begin
                    m_ready = 1'b1;
                    m_rdata = mem_val(m_addr);
                    t.addr  = m_addr;
                    t.wdata = m_wdata;
                    t.wstrb = m_wstrb;
                    txq.push_back(t);
                end
            end else begin
                if (prev_valid) drop_err++;
                prev_valid = 1'b0;
                low_cnt++;
            end
        end
    end

    task automatic clear_logs();
        txq.delete();
        gap_q.delete();
        after_hs = 1'b0;
    endtask

    task automatic cfg_access(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, output logic [31:0] rdata);
        int waited;
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = wr ? wdata : 32'h0;
        cfg_wstrb = wr ? wstrb : 4'h0;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!cfg_ready && waited < 8);
        check("cfg_ready_latency", 32'(waited), 32'd1);
        rdata     = cfg_rdata;
        cfg_valid = 1'b0;
        cfg_wstrb = 4'h0;
    endtask

    task automatic cfg_wr(input logic [3:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        logic [31:0] dummy;
        cfg_access(1'b1, addr, wdata, wstrb, dummy);
    endtask

    task automatic cfg_rd_check(input string name, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        cfg_access(1'b0, addr, 32'h0, 4'h0, rd);
        check(name, rd, exp);
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while (!done_o && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("wait_done", {31'h0, done_o}, 32'h1);
    endtask

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[16];

    initial begin
        logic [31:0] rd;
        int n;

        vt[0]  = '{1'b0, A_SRC,  32'h0,         4'h0, 32'h0000_0000};
        vt[1]  = '{1'b0, A_CTRL, 32'h0,         4'h0, 32'h0000_0000};
        vt[2]  = '{1'b1, A_SRC,  32'h1234_5677, 4'hF, 32'h0};
        vt[3]  = '{1'b0, A_SRC,  32'h0,         4'h0, 32'h1234_5674};
        vt[4]  = '{1'b1, A_SRC,  32'hAABB_CCDD, 4'h5, 32'h0};
        vt[5]  = '{1'b0, A_SRC,  32'h0,         4'h0, 32'h12BB_56DC};
        vt[6]  = '{1'b1, A_DST,  32'hFFFF_FFFF, 4'h8, 32'h0};
        vt[7]  = '{1'b0, A_DST,  32'h0,         4'h0, 32'hFF00_0000};
        vt[8]  = '{1'b1, A_LEN,  32'hABCD_1234, 4'hF, 32'h0};
        vt[9]  = '{1'b0, A_LEN,  32'h0,         4'h0, 32'h0000_1234};
        vt[10] = '{1'b1, A_LEN,  32'h0000_5600, 4'h2, 32'h0};
        vt[11] = '{1'b0, A_LEN,  32'h0,         4'h0, 32'h0000_5634};
        vt[12] = '{1'b1, A_CTRL, 32'h0000_0002, 4'h1, 32'h0};
        vt[13] = '{1'b0, A_CTRL, 32'h0,         4'h0, 32'h0000_0000};
        vt[14] = '{1'b1, A_CTRL, 32'h0000_0004, 4'h1, 32'h0};
        vt[15] = '{1'b0, A_CTRL, 32'h0,         4'h0, 32'h0000_0000};

        // Reset state
        #12;
        check("rst_m_valid",   {31'h0, m_valid},   32'h0);
        check("rst_cfg_ready", {31'h0, cfg_ready}, 32'h0);
        check("rst_done_o",    {31'h0, done_o},    32'h0);
        check("rst_m_addr",    m_addr,             32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Register file vectors
        for (int i = 0; i < 16; i++) begin
            cfg_access(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].wstrb, rd);
            if (!vt[i].wr) check($sformatf("vec%0d", i), rd, vt[i].exp);
        end
        @(negedge clk);
        check("cfg_ready_pulse", {31'h0, cfg_ready}, 32'h0);

        // Three-word copy, latency 1
        lat = 1;
        cfg_wr(A_SRC, 32'h0000_0100, 4'hF);
        cfg_wr(A_DST, 32'h0500_0000, 4'hF);
        cfg_wr(A_LEN, 32'h0000_0003, 4'hF);
        clear_logs();
        cfg_wr(A_CTRL, 32'h1, 4'h1);
        check("mvalid_during_ack", {31'h0, m_valid}, 32'h0);
        @(negedge clk);
        check("mvalid_rise", {31'h0, m_valid}, 32'h1);
        wait_done(200);
        check("copy3_txn_count", 32'(txq.size()), 32'd6);
        if (txq.size() == 6) begin
            for (int w = 0; w < 3; w++) begin
                check($sformatf("copy3_rd%0d_addr", w), txq[2*w].addr, 32'h100 + 32'(4*w));
                check($sformatf("copy3_rd%0d_strb", w), {28'h0, txq[2*w].wstrb}, 32'h0);
                check($sformatf("copy3_wr%0d_addr", w), txq[2*w+1].addr, 32'h0500_0000 + 32'(4*w));
                check($sformatf("copy3_wr%0d_strb", w), {28'h0, txq[2*w+1].wstrb}, 32'hF);
                check($sformatf("copy3_wr%0d_data", w), txq[2*w+1].wdata, mem_val(32'h100 + 32'(4*w)));
            end
        end
        check("copy3_gap_count", 32'(gap_q.size()), 32'd5);
        foreach (gap_q[g]) check($sformatf("copy3_gap%0d", g), 32'(gap_q[g]), 32'd1);
        cfg_rd_check("copy3_status", A_CTRL, 32'h2);
        cfg_rd_check("copy3_len",    A_LEN,  32'h0);
        cfg_rd_check("copy3_src",    A_SRC,  32'h0000_010C);
        cfg_rd_check("copy3_dst",    A_DST,  32'h0500_000C);

        // Zero-length start
        cfg_wr(A_CTRL, 32'h2, 4'h1);
        clear_logs();
        cfg_wr(A_CTRL, 32'h1, 4'h1);
        check("zlen_done_during_ack", {31'h0, done_o}, 32'h0);
        @(negedge clk);
        check("zlen_done_after_ack", {31'h0, done_o}, 32'h1);
        cfg_rd_check("zlen_status", A_CTRL, 32'h2);
        repeat (4) @(negedge clk);
        check("zlen_no_txn", 32'(txq.size()), 32'd0);

        // Abort during the second read, latency 5
        lat = 5;
        cfg_wr(A_SRC, 32'h0000_0200, 4'hF);
        cfg_wr(A_DST, 32'h0000_0300, 4'hF);
        cfg_wr(A_LEN, 32'h0000_0004, 4'hF);
        clear_logs();
        cfg_wr(A_CTRL, 32'h1, 4'h1);
        n = 0;
        while (!(m_valid && m_wstrb == 4'h0 && m_addr == 32'h204) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach_rd2", {31'h0, m_valid}, 32'h1);
        cfg_wr(A_CTRL, 32'h4, 4'h1);
        repeat (20) @(negedge clk);
        check("abort_txn_count", 32'(txq.size()), 32'd3);
        if (txq.size() >= 3) check("abort_last_addr", txq[2].addr, 32'h204);
        check("abort_no_drop", 32'(drop_err), 32'd0);
        check("abort_mvalid_low", {31'h0, m_valid}, 32'h0);
        cfg_rd_check("abort_status", A_CTRL, 32'h4);
        cfg_rd_check("abort_len",    A_LEN,  32'h3);
        cfg_rd_check("abort_src",    A_SRC,  32'h204);

        // Register writes and START while busy are ignored
        lat = 1;
        cfg_wr(A_SRC, 32'h0000_0400, 4'hF);
        cfg_wr(A_DST, 32'h0000_0800, 4'hF);
        cfg_wr(A_LEN, 32'h0000_0003, 4'hF);
        clear_logs();
        cfg_wr(A_CTRL, 32'h1, 4'h1);
        cfg_rd_check("busy_status", A_CTRL, 32'h1);
        cfg_wr(A_SRC, 32'hDEAD_BEE0, 4'hF);
        cfg_wr(A_CTRL, 32'h1, 4'h1);
        cfg_wr(A_LEN, 32'h0000_0007, 4'hF);
        wait_done(200);
        check("busy_txn_count", 32'(txq.size()), 32'd6);
        if (txq.size() == 6) begin
            check("busy_rd1_addr", txq[2].addr, 32'h404);
            check("busy_rd2_addr", txq[4].addr, 32'h408);
        end
        cfg_rd_check("busy_src", A_SRC, 32'h40C);
        cfg_rd_check("busy_len", A_LEN, 32'h0);

        // Address wrap
        cfg_wr(A_SRC, 32'hFFFF_FFFC, 4'hF);
        cfg_wr(A_DST, 32'h0000_0010, 4'hF);
        cfg_wr(A_LEN, 32'h0000_0002, 4'hF);
        clear_logs();
        cfg_wr(A_CTRL, 32'h1, 4'h1);
        wait_done(200);
        check("wrap_txn_count", 32'(txq.size()), 32'd4);
        if (txq.size() == 4) begin
            check("wrap_rd0_addr", txq[0].addr, 32'hFFFF_FFFC);
            check("wrap_rd1_addr", txq[2].addr, 32'h0000_0000);
            check("wrap_wr1_addr", txq[3].addr, 32'h0000_0014);
        end
        cfg_rd_check("wrap_src", A_SRC, 32'h4);

        // CLRDONE landing on the completion edge: DONE stays set
        cfg_wr(A_SRC, 32'h0000_0040, 4'hF);
        cfg_wr(A_LEN, 32'h0000_0001, 4'hF);
        cfg_wr(A_CTRL, 32'h1, 4'h1);
        repeat (3) @(negedge clk);
        cfg_wr(A_CTRL, 32'h2, 4'h1);
        check("clr_coincide_done", {31'h0, done_o}, 32'h1);
        cfg_wr(A_CTRL, 32'h2, 4'h1);
        cfg_rd_check("clr_after_status", A_CTRL, 32'h0);

        // Asynchronous reset during a write request
        lat = 5;
        cfg_wr(A_SRC, 32'h0000_0600, 4'hF);
        cfg_wr(A_DST, 32'h0000_0700, 4'hF);
        cfg_wr(A_LEN, 32'h0000_0002, 4'hF);
        clear_logs();
        cfg_wr(A_CTRL, 32'h1, 4'h1);
        n = 0;
        while (!(m_valid && m_wstrb == 4'hF) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach_wr", {31'h0, m_valid}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_mvalid", {31'h0, m_valid}, 32'h0);
        check("rst_async_wstrb",  {28'h0, m_wstrb}, 32'h0);
        check("rst_async_done",   {31'h0, done_o},  32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cfg_rd_check("rst_src",    A_SRC,  32'h0);
        cfg_rd_check("rst_dst",    A_DST,  32'h0);
        cfg_rd_check("rst_len",    A_LEN,  32'h0);
        cfg_rd_check("rst_status", A_CTRL, 32'h0);
        repeat (10) @(negedge clk);
        check("rst_no_write", 32'(txq.size()), 32'd1);

        check("stability", 32'(stab_err), 32'd0);
        check("no_drop",   32'(drop_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/native_bus_dma.md
NATIVE_BUS_DMA -- requirements
Module: native_bus_dma

Interface
REQ-001 SHALL have parameter LEN_W, default 16, giving the width of the transfer-length register in words.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports cfg_valid in 1, cfg_ready out 1, cfg_addr in 4, cfg_wdata in 32, cfg_wstrb in 4, cfg_rdata out 32; together these form the native-bus register responder.
REQ-005 SHALL have ports m_valid out 1, m_ready in 1, m_addr out 32, m_wdata out 32, m_wstrb out 4, m_rdata in 32; together these form the native-bus initiator port.
REQ-006 SHALL have port done_o  output  1  mirrors the sticky DONE flag.

Function
REQ-007 Register map (cfg_addr[3:2]): 0 SRC, 1 DST, 2 LEN (LEN_W bits, zero-extended on read), 3 CTRL/STATUS.
REQ-008 SRC and DST bits [1:0] SHALL always read 0; written bits [1:0] are discarded.
REQ-009 cfg_ready SHALL rise in the cycle after cfg_valid is sampled with cfg_ready low.
REQ-010 cfg_ready SHALL be a one-cycle pulse; cfg_rdata is registered and valid only during that pulse.
REQ-011 Register writes SHALL honour cfg_wstrb per byte and take effect on the edge that raises cfg_ready.
REQ-012 Writes to SRC, DST or LEN while BUSY SHALL be ignored (the access is still acknowledged).
REQ-013 CTRL write fields: bit0 START, bit1 CLRDONE, bit2 ABORT; each is write-1 and self-clearing.
REQ-014 STATUS read fields: bit0 BUSY, bit1 DONE, bit2 ABORTED; bits 31:3 read 0.
REQ-015 START when idle with LEN≠0 SHALL clear DONE and ABORTED and enter RD_REQ; m_valid first rises in the cycle after the cfg_ready pulse.
REQ-016 START when idle with LEN=0 SHALL set DONE in the cycle after the cfg_ready pulse and issue no bus transaction.
REQ-017 START while BUSY SHALL be ignored.
REQ-018 States: IDLE, RD_REQ, RD_GAP, WR_REQ, WR_GAP.
REQ-019 RD_REQ: m_valid=1, m_addr=SRC, m_wstrb=0; holds until m_ready, then latches m_rdata into the data register and goes to RD_GAP.
REQ-020 RD_GAP: m_valid=0 for exactly one cycle, then WR_REQ.
REQ-021 WR_REQ: m_valid=1, m_addr=DST, m_wdata=data register, m_wstrb=4'b1111; holds until m_ready, then goes to WR_GAP.
REQ-022 In the m_ready cycle of WR_REQ: SRC+=4, DST+=4, LEN-=1.
REQ-023 WR_GAP: m_valid=0 for one cycle; then RD_REQ if LEN≠0, else IDLE with DONE set.
REQ-024 m_addr, m_wdata and m_wstrb SHALL remain stable while m_valid is high.
REQ-025 m_valid SHALL never be dropped before m_ready is seen.
REQ-026 An m_ready sampled while m_valid is low SHALL be ignored.
REQ-027 SRC/DST increments SHALL wrap modulo 2^32 (0xFFFF_FFFC+4 gives 0x0000_0000).
REQ-028 ABORT while BUSY SHALL complete any in-progress RD_REQ/WR_REQ handshake, then enter IDLE with ABORTED=1 and DONE unchanged.
REQ-029 After ABORT, no further transaction SHALL start; a read aborted in RD_REQ issues no write.
REQ-030 ABORT while idle SHALL have no effect.
REQ-031 CLRDONE SHALL clear DONE.
REQ-032 If CLRDONE coincides with the completion edge, DONE SHALL end set.
REQ-033 BUSY SHALL equal (state≠IDLE).
REQ-034 SRC, DST and LEN SHALL read back their live, progressing values during a transfer.

Reset
REQ-035 While rst is high, all of the following SHALL be forced immediately: state IDLE, m_valid 0, m_wstrb 0, m_addr 0, m_wdata 0, cfg_ready 0, cfg_rdata 0, SRC/DST/LEN/data 0, DONE/ABORTED 0, done_o 0.
REQ-036 Reset mid-transaction SHALL abandon the transaction with no completion and no DONE.

Verification
REQ-037 SRC=0x100, DST=0x0500_0000, LEN=3, START, responder latency 1 -> reads 0x100/0x104/0x108 each followed by a write to 0x0500_0000/04/08 with wstrb 1111 and matching data; one m_valid-low cycle between transactions; DONE=1, BUSY=0, LEN reads 0, SRC reads 0x10C.
REQ-038 LEN=0, START -> m_valid never rises; STATUS reads 0x2 on the next access; done_o=1.
REQ-039 LEN=4, responder latency 5, ABORT while in RD_REQ of word 2 -> m_valid held until m_ready, no write issued, STATUS=0x4, LEN=3.
REQ-040 While BUSY, write SRC=0xDEAD_BEE0 and START again -> SRC continues from its prior progression; the transfer length is unchanged.
REQ-041 SRC=0xFFFF_FFFC, LEN=2 -> second read address is 0x0000_0000.
REQ-042 rst asserted during WR_REQ -> m_valid falls without waiting for a clock edge; all registers read 0 after release; no DONE.
